evm_multi: RTL

Parameterised N-candidate electronic voting controller, successor to the fixed three-candidate EVM core. It takes one vote per authorised voter from a one-hot button bus and rejects multi-press votes with an explicit pulse. Per-candidate tallies saturate and raise a sticky overflow flag. Idle timeouts are per stage, and a post-session result view gives readout by index, unique-winner detection and a grand total. It sits between the ballot-unit button debouncers and the control/display unit.

---
 rtl/evm_multi.sv | 242 ++++++++++++++++++++++++
 1 files changed

// File: rtl/evm_multi.sv
`default_nettype none
// ============================================================================
// Module   : evm_multi
// Purpose  : N-candidate electronic voting controller. Accepts one one-hot
//            vote per authorised voter, rejects multi-press votes, keeps
//            saturating per-candidate tallies with a sticky overflow flag,
//            applies per-stage idle timeouts and presents a result view
//            (readout by index, unique winner, tie, grand total) in DONE.
// Ports    : clk, rst (async, active-low)
//            power_on_i      - sync enable, low clears everything
//            voter_ready_i   - authorise one voter
//            vote_i          - one-hot button bus, bit i = candidate i+1
//            session_close_i - end polling
//            rd_idx_i        - candidate index to read out (1..NUM_CAND)
//            in_progress_o, done_o           - state decodes
//            vote_ack_o, vote_reject_o, timeout_o - registered 1-cycle pulses
//            overflow_o      - sticky tally saturation flag
//            rd_count_o, winner_idx_o, tie_o, total_o - results (DONE only)
// Revision : 1.0 - initial release
// ============================================================================
module evm_multi #(
  parameter int NUM_CAND = 4,
  parameter int WIDTH    = 8,
  parameter int IDX_W    = 4,
  parameter int TIMEOUT  = 100
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   power_on_i,
  input  logic                   voter_ready_i,
  input  logic [NUM_CAND-1:0]    vote_i,
  input  logic                   session_close_i,
  input  logic [IDX_W-1:0]       rd_idx_i,
  output logic                   in_progress_o,
  output logic                   done_o,
  output logic                   vote_ack_o,
  output logic                   vote_reject_o,
  output logic                   timeout_o,
  output logic                   overflow_o,
  output logic [WIDTH-1:0]       rd_count_o,
  output logic [IDX_W-1:0]       winner_idx_o,
  output logic                   tie_o,
  output logic [WIDTH+IDX_W-1:0] total_o
);

  localparam int               TOT_W       = WIDTH + IDX_W;
  localparam logic [WIDTH-1:0] c_tally_max = '1;
  // Expiry fires on the TIMEOUT-th idle edge, i.e. when the count of
  // previously elapsed idle cycles equals TIMEOUT-1.
  localparam logic [15:0]      c_timer_last = 16'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_WAIT_VOTER = 3'd1,
    S_WAIT_VOTE  = 3'd2,
    S_COMMIT     = 3'd3,
    S_DONE       = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [15:0]        timer_q, timer_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               ack_q, ack_d;
  logic               rej_q, rej_d;
  logic               to_q, to_d;
  logic               ovf_q;
  logic [WIDTH-1:0]   tally_q [NUM_CAND];
  logic [TOT_W-1:0]   total_q;

  logic               w_commit;
  logic               w_any, w_multi;
  logic [IDX_W-1:0]   w_sel;
  logic [WIDTH-1:0]   w_cur;
  logic [WIDTH-1:0]   w_max;
  logic               w_seen, w_dup;
  logic [IDX_W-1:0]   w_lead;
  logic [WIDTH-1:0]   w_rd;
  logic               w_done;

  // Button bus decode: any press, more than one press, and the 0-based
  // index of the pressed button (meaningful only for a single press).
  always_comb begin
    w_any   = 1'b0;
    w_multi = 1'b0;
    w_sel   = '0;
    for (int i = 0; i < NUM_CAND; i++) begin
      if (vote_i[i]) begin
        if (w_any) w_multi = 1'b1;
        w_any = 1'b1;
        w_sel = IDX_W'(i);
      end
    end
  end

  // Tally currently selected by the latched index.
  always_comb begin
    w_cur = '0;
    for (int i = 0; i < NUM_CAND; i++) begin
      if (idx_q == IDX_W'(i)) w_cur = tally_q[i];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      timer_q <= '0;
      idx_q   <= '0;
      ack_q   <= 1'b0;
      rej_q   <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      idx_q   <= idx_d;
      ack_q   <= ack_d;
      rej_q   <= rej_d;
      to_q    <= to_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    idx_d    = idx_q;
    ack_d    = 1'b0;
    rej_d    = 1'b0;
    to_d     = 1'b0;
    w_commit = 1'b0;
    if (!power_on_i) begin
      state_d = S_IDLE;
      timer_d = '0;
      idx_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_d = S_WAIT_VOTER;
          timer_d = '0;
        end
        S_WAIT_VOTER: begin
          if (voter_ready_i) begin
            state_d = S_WAIT_VOTE;
            timer_d = '0;
          end else if (session_close_i) begin
            state_d = S_DONE;
          end else if (timer_q == c_timer_last) begin
            state_d = S_DONE;
            to_d    = 1'b1;
          end else begin
            timer_d = timer_q + 16'd1;
          end
        end
        S_WAIT_VOTE: begin
          if (w_any && !w_multi) begin
            idx_d   = w_sel;
            state_d = S_COMMIT;
          end else if (w_multi) begin
            rej_d   = 1'b1;
            timer_d = '0;
          end else if (timer_q == c_timer_last) begin
            state_d = S_WAIT_VOTER;
            timer_d = '0;
            to_d    = 1'b1;
          end else begin
            timer_d = timer_q + 16'd1;
          end
        end
        S_COMMIT: begin
          w_commit = 1'b1;
          ack_d    = 1'b1;
          state_d  = S_WAIT_VOTER;
          timer_d  = '0;
        end
        S_DONE: begin
          state_d = S_DONE;
        end
        default: begin
          state_d = S_IDLE;
          timer_d = '0;
        end
      endcase
    end
  end

  // Tally / total / overflow datapath. A vote against a saturated tally is
  // dropped and only sets the sticky flag, so total always equals the sum.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_CAND; i++) tally_q[i] <= '0;
      total_q <= '0;
      ovf_q   <= 1'b0;
    end else if (!power_on_i) begin
      for (int i = 0; i < NUM_CAND; i++) tally_q[i] <= '0;
      total_q <= '0;
      ovf_q   <= 1'b0;
    end else if (w_commit) begin
      if (w_cur == c_tally_max) begin
        ovf_q <= 1'b1;
      end else begin
        total_q <= total_q + TOT_W'(1);
        for (int i = 0; i < NUM_CAND; i++) begin
          if (idx_q == IDX_W'(i)) tally_q[i] <= tally_q[i] + WIDTH'(1);
        end
      end
    end
  end

  // Result view: maximum, uniqueness of the maximum, and indexed readout.
  always_comb begin
    w_max = '0;
    for (int i = 0; i < NUM_CAND; i++) begin
      if (tally_q[i] > w_max) w_max = tally_q[i];
    end
    w_seen = 1'b0;
    w_dup  = 1'b0;
    w_lead = '0;
    for (int i = 0; i < NUM_CAND; i++) begin
      if (tally_q[i] == w_max) begin
        if (w_seen) w_dup = 1'b1;
        w_seen = 1'b1;
        w_lead = IDX_W'(i + 1);
      end
    end
    w_rd = '0;
    for (int i = 0; i < NUM_CAND; i++) begin
      if (rd_idx_i == IDX_W'(i + 1)) w_rd = tally_q[i];
    end
  end

  assign w_done        = (state_q == S_DONE);
  assign done_o        = w_done;
  assign in_progress_o = (state_q == S_WAIT_VOTE);
  assign vote_ack_o    = ack_q;
  assign vote_reject_o = rej_q;
  assign timeout_o     = to_q;
  assign overflow_o    = ovf_q;
  assign rd_count_o    = w_done ? w_rd : '0;
  assign winner_idx_o  = (w_done && !w_dup) ? w_lead : '0;
  assign tie_o         = w_done && w_dup;
  assign total_o       = w_done ? total_q : '0;

endmodule
`default_nettype wire
